// File: rtl/grid_line_clear_ctrl_pkg.sv
// grid_line_clear_ctrl_pkg: shared grid geometry, empty-cell value and sequencer state encoding
package grid_line_clear_ctrl_pkg;
  localparam int GRID_COLS  = 10;
  localparam int GRID_ROWS  = 20;
  localparam int EMPTY_CELL = 0;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/grid_line_clear_ctrl_row_walker.sv
// grid_line_clear_ctrl_row_walker: column counter plus running cell address shared by every row walk
//  i_load/i_base  restart the walk at i_base, column 0 (wins over i_step)
//  i_step         advance column and address by one
//  i_last_col     column index reported as the final one of this walk
//  o_addr         current cell address
//  o_waddr        o_addr from the previous cycle (write side of a 1-cycle read pipeline)
//  o_first/o_last column is 0 / column equals i_last_col
module grid_line_clear_ctrl_row_walker #(
  parameter int ADDR_WIDTH = 8,
  parameter int COL_W      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic                  i_step,
  input  logic [COL_W-1:0]      i_last_col,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic                  o_first,
  output logic                  o_last
);
  logic [COL_W-1:0]      r_col;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_waddr;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col   <= '0;
      r_addr  <= '0;
      r_waddr <= '0;
    end else begin
      r_waddr <= r_addr;
      if (i_load) begin
        r_col  <= '0;
        r_addr <= i_base;
      end else if (i_step) begin
        r_col  <= r_col + COL_W'(1);
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end
  assign o_addr  = r_addr;
  assign o_waddr = r_waddr;
  assign o_first = (r_col == '0);
  assign o_last  = (r_col == i_last_col);
endmodule

// File: rtl/grid_line_clear_ctrl.sv
// grid_line_clear_ctrl: line-clear sequencer sharing the dual-port grid memory with the host
//  i_clk, i_rst_n           clock, asynchronous active-low reset
//  i_start                  request a pass (only honoured while idle)
//  o_busy, o_done           pass in progress / one-cycle end-of-pass pulse
//  o_lines_cleared          rows removed in the last pass
//  o_host_grant             host owns the memory ports
//  i_host_*                 host port-A write and port-B read requests
//  o_mem_*, i_mem_q_b       memory ports; q_b is registered, valid one cycle after addr_b
module grid_line_clear_ctrl
  import grid_line_clear_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int COLS       = GRID_COLS,
  parameter int ROWS       = GRID_ROWS,
  parameter int CNT_W      = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_lines_cleared,
  output logic                  o_host_grant,
  input  logic [ADDR_WIDTH-1:0] i_host_addr_a,
  input  logic [DATA_WIDTH-1:0] i_host_data_a,
  input  logic                  i_host_we_a,
  input  logic [ADDR_WIDTH-1:0] i_host_addr_b,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_a,
  output logic [DATA_WIDTH-1:0] o_mem_data_a,
  output logic                  o_mem_we_a,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_b,
  input  logic [DATA_WIDTH-1:0] i_mem_q_b
);
  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] BOT_BASE = ADDR_WIDTH'((ROWS - 1) * COLS);
  localparam logic [ROW_W-1:0]      BOT_ROW  = ROW_W'(ROWS - 1);
  state_t                r_state, w_state_nx;
  logic [ROW_W-1:0]      r_row, w_row_nx;
  logic [ROW_W-1:0]      r_dst, w_dst_nx;
  logic [ADDR_WIDTH-1:0] r_base, w_base_nx;
  logic [ADDR_WIDTH-1:0] r_src, w_src_nx;
  logic                  r_full, w_full_nx;
  logic [CNT_W-1:0]      r_lines, w_lines_nx;
  logic                  w_load;
  logic [ADDR_WIDTH-1:0] w_load_base;
  logic                  w_step;
  logic [COL_W-1:0]      w_last_col;
  logic [ADDR_WIDTH-1:0] w_wk_addr, w_wk_waddr;
  logic                  w_wk_first, w_wk_last;
  logic                  w_row_full;
  logic                  w_ctrl_we;
  logic [ADDR_WIDTH-1:0] w_ctrl_addr_a;
  logic [DATA_WIDTH-1:0] w_ctrl_data_a;
  // CLEAR walks COLS cells; SCAN and SHIFT need one extra cycle to drain the read pipeline
  assign w_last_col = (r_state == ST_CLEAR) ? COL_W'(COLS - 1) : COL_W'(COLS);
  assign w_step     = (r_state != ST_IDLE);
  // q_b carries the cell read last cycle, so it is folded into the running AND
  assign w_row_full = r_full & (i_mem_q_b != DATA_WIDTH'(EMPTY_CELL));
  grid_line_clear_ctrl_row_walker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .COL_W     (COL_W)
  ) u_walker (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_base    (w_load_base),
    .i_step    (w_step),
    .i_last_col(w_last_col),
    .o_addr    (w_wk_addr),
    .o_waddr   (w_wk_waddr),
    .o_first   (w_wk_first),
    .o_last    (w_wk_last)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_dst   <= '0;
      r_base  <= '0;
      r_src   <= '0;
      r_full  <= 1'b0;
      r_lines <= '0;
    end else begin
      r_state <= w_state_nx;
      r_row   <= w_row_nx;
      r_dst   <= w_dst_nx;
      r_base  <= w_base_nx;
      r_src   <= w_src_nx;
      r_full  <= w_full_nx;
      r_lines <= w_lines_nx;
    end
  end
  always_comb begin
    w_state_nx    = r_state;
    w_row_nx      = r_row;
    w_dst_nx      = r_dst;
    w_base_nx     = r_base;
    w_src_nx      = r_src;
    w_full_nx     = r_full;
    w_lines_nx    = r_lines;
    w_load        = 1'b0;
    w_load_base   = r_base;
    w_ctrl_we     = 1'b0;
    w_ctrl_addr_a = w_wk_addr;
    w_ctrl_data_a = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nx  = ST_SCAN;
          w_row_nx    = BOT_ROW;
          w_base_nx   = BOT_BASE;
          w_full_nx   = 1'b1;
          w_lines_nx  = '0;
          w_load      = 1'b1;
          w_load_base = BOT_BASE;
        end
      end
      ST_SCAN: begin
        if (!w_wk_first) w_full_nx = w_row_full;
        if (w_wk_last) begin
          w_load    = 1'b1;
          w_full_nx = 1'b1;
          if (w_row_full) begin
            // a full row 0 has nothing above it to copy, so go straight to CLEAR
            w_lines_nx  = r_lines + CNT_W'(1);
            w_dst_nx    = r_row;
            w_src_nx    = r_base - STRIDE;
            w_state_nx  = (r_row == '0) ? ST_CLEAR : ST_SHIFT;
            w_load_base = (r_row == '0) ? '0 : r_base - STRIDE;
          end else if (r_row != '0) begin
            w_row_nx    = r_row - ROW_W'(1);
            w_base_nx   = r_base - STRIDE;
            w_load_base = r_base - STRIDE;
          end else begin
            w_state_nx = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        // walker reads the source row; the cell read last cycle lands one row lower
        w_ctrl_we     = !w_wk_first;
        w_ctrl_addr_a = w_wk_waddr + STRIDE;
        w_ctrl_data_a = i_mem_q_b;
        if (w_wk_last) begin
          w_load      = 1'b1;
          w_dst_nx    = r_dst - ROW_W'(1);
          w_src_nx    = r_src - STRIDE;
          w_state_nx  = (r_dst == ROW_W'(1)) ? ST_CLEAR : ST_SHIFT;
          w_load_base = (r_dst == ROW_W'(1)) ? '0 : r_src - STRIDE;
        end
      end
      ST_CLEAR: begin
        w_ctrl_we = 1'b1;
        if (w_wk_last) begin
          // rescan the same row: the row that just dropped into it may be full too
          w_state_nx  = ST_SCAN;
          w_full_nx   = 1'b1;
          w_load      = 1'b1;
          w_load_base = r_base;
        end
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = (r_state == ST_DONE);
  assign o_lines_cleared = r_lines;
  assign o_host_grant    = ~o_busy;
  assign o_mem_addr_a    = o_busy ? w_ctrl_addr_a : i_host_addr_a;
  assign o_mem_data_a    = o_busy ? w_ctrl_data_a : i_host_data_a;
  assign o_mem_we_a      = o_busy ? w_ctrl_we     : i_host_we_a;
  assign o_mem_addr_b    = o_busy ? w_wk_addr     : i_host_addr_b;
endmodule
